// File: rtl/johnson_decoder_pkg.sv
// Shared definitions for the Johnson-code receive path: lock FSM states and index width helper.
// Combinational definitions only; no latency and no flow control.
package johnson_decoder_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACK    = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    // Index width for a WIDTH-bit Johnson code (2*WIDTH states).
    function automatic int idx_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Checks a Johnson code for legality and converts it to its sequence index.
// Purely combinational (0 cycles); no flow control.
module johnson_code_check
    import johnson_decoder_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] c,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    int               pc;
    logic [WIDTH-1:0] low_mask;
    logic [WIDTH-1:0] high_mask;

    // A legal code is a run of ones anchored at the LSB (rising half) or at the MSB (falling half).
    always_comb begin
        pc        = $countones(c);
        low_mask  = '0;
        high_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            low_mask[i]  = (i < pc);
            high_mask[i] = (i >= WIDTH - pc);
        end
        legal = c[WIDTH-1] ? (c == high_mask) : (c == low_mask);
        idx   = c[WIDTH-1] ? IDX_W'(2 * WIDTH - pc) : IDX_W'(pc);
    end

endmodule

// File: rtl/johnson_decoder.sv
// Decodes sampled Johnson codes to binary/one-hot, tracks forward stepping with a lock FSM, counts errors.
// One cycle from in_valid to out_valid; no backpressure, every in_valid sample is consumed.
module johnson_decoder
    import johnson_decoder_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8,
    localparam int IDX_W     = idx_width(WIDTH)
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   johnson_in,
    output logic               out_valid,
    output logic [IDX_W-1:0]   bin_out,
    output logic [2*WIDTH-1:0] onehot_out,
    output logic               illegal,
    output logic               seq_err,
    output logic               locked,
    output logic [ERR_W-1:0]   err_count
);

    localparam int                 GCNT_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(2 * WIDTH - 1);
    localparam logic [GCNT_W-1:0]  GCNT_MAX = GCNT_W'(LOCK_COUNT);
    localparam logic [2*WIDTH-1:0] ONE_HOT0 = {{(2*WIDTH-1){1'b0}}, 1'b1};

    lock_state_t       state;
    logic [IDX_W-1:0]  ref_idx;
    logic [GCNT_W-1:0] gcnt;

    logic              legal;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  succ_idx;
    logic              is_hold;
    logic              is_succ;
    logic              err_evt;

    johnson_code_check #(.WIDTH(WIDTH)) u_check (
        .c     (johnson_in),
        .legal (legal),
        .idx   (idx)
    );

    // Explicit wrap keeps the successor correct when 2*WIDTH is not a power of two.
    assign succ_idx = (ref_idx == LAST_IDX) ? '0 : ref_idx + 1'b1;
    assign is_hold  = (idx == ref_idx);
    assign is_succ  = (idx == succ_idx);
    assign err_evt  = in_valid && (!legal || (state != UNLOCKED && !is_hold && !is_succ));
    assign locked   = (state == LOCKED);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= UNLOCKED;
            ref_idx    <= '0;
            gcnt       <= '0;
            out_valid  <= 1'b0;
            bin_out    <= '0;
            onehot_out <= '0;
            illegal    <= 1'b0;
            seq_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                illegal    <= !legal;
                bin_out    <= legal ? idx : '0;
                onehot_out <= legal ? (ONE_HOT0 << idx) : '0;
                seq_err    <= 1'b0;
                if (err_evt && err_count != '1)
                    err_count <= err_count + 1'b1;

                if (!legal) begin
                    state <= UNLOCKED;
                    gcnt  <= '0;
                end else begin
                    case (state)
                        UNLOCKED: begin
                            state   <= TRACK;
                            ref_idx <= idx;
                            gcnt    <= '0;
                        end
                        TRACK, LOCKED: begin
                            if (is_succ) begin
                                ref_idx <= idx;
                                // Once locked the step counter has done its job and stays put.
                                if (state == TRACK) begin
                                    gcnt <= gcnt + 1'b1;
                                    if (gcnt + 1'b1 == GCNT_MAX)
                                        state <= LOCKED;
                                end
                            end else if (!is_hold) begin
                                seq_err <= 1'b1;
                                ref_idx <= idx;
                                gcnt    <= '0;
                                state   <= TRACK;
                            end
                        end
                        default: state <= UNLOCKED;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// Randomised and directed bench for johnson_decoder against a sequence-table reference model.
module tb_johnson_decoder;

    localparam int N  = 4;
    localparam int NS = 2 * N;
    localparam int LC = 4;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] johnson_in = 4'b0000;

    logic       out_valid, illegal, seq_err, locked;
    logic [2:0] bin_out;
    logic [7:0] onehot_out;
    logic [7:0] err_count;

    logic       ov2, ill2, seq2, lk2;
    logic [2:0] bin2;
    logic [7:0] oh2;
    logic [1:0] err2;

    johnson_decoder #(.WIDTH(N), .LOCK_COUNT(LC), .ERR_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .johnson_in(johnson_in),
        .out_valid(out_valid), .bin_out(bin_out), .onehot_out(onehot_out),
        .illegal(illegal), .seq_err(seq_err), .locked(locked), .err_count(err_count)
    );

    johnson_decoder #(.WIDTH(N), .LOCK_COUNT(LC), .ERR_W(2)) dut_sat (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .johnson_in(johnson_in),
        .out_valid(ov2), .bin_out(bin2), .onehot_out(oh2),
        .illegal(ill2), .seq_err(seq2), .locked(lk2), .err_count(err2)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [3:0] code_tab [NS];

    // Reference model state
    bit   m_ov, m_ill, m_seq, m_lk, have_ref;
    int   m_bin, m_ref, m_run, m_errs;
    logic [7:0] m_oh;

    function automatic int m_decode(input logic [3:0] c);
        for (int i = 0; i < NS; i++)
            if (code_tab[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_ov = 0; m_ill = 0; m_seq = 0; m_lk = 0; have_ref = 0;
        m_bin = 0; m_ref = 0; m_run = 0; m_errs = 0; m_oh = '0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] c);
        int k;
        m_ov = v;
        if (!v) return;
        k = m_decode(c);
        m_seq = 0;
        if (k < 0) begin
            m_ill = 1; m_bin = 0; m_oh = '0;
            have_ref = 0; m_lk = 0; m_run = 0; m_errs++;
        end else begin
            m_ill = 0; m_bin = k; m_oh = 8'(1) << k;
            if (!have_ref) begin
                have_ref = 1; m_ref = k; m_run = 0; m_lk = 0;
            end else if (k == (m_ref + 1) % NS) begin
                m_ref = k;
                if (!m_lk) begin
                    m_run++;
                    if (m_run == LC) m_lk = 1;
                end
            end else if (k != m_ref) begin
                m_seq = 1; m_errs++; m_ref = k; m_run = 0; m_lk = 0;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit v, input logic [3:0] c);
        Reset = rst; in_valid = v; johnson_in = c;
        @(posedge CLK);
        #1;
        if (rst) model_reset();
        else model_step(v, c);
    endtask

    function automatic logic [24:0] observed();
        return {out_valid, bin_out, onehot_out, illegal, seq_err, locked, err_count, err2};
    endfunction

    function automatic logic [24:0] expected();
        int e8, e2;
        e8 = (m_errs > 255) ? 255 : m_errs;
        e2 = (m_errs > 3) ? 3 : m_errs;
        return {m_ov, 3'(m_bin), m_oh, m_ill, m_seq, m_lk, 8'(e8), 2'(e2)};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1, 4'b0011);
            total++;
            if (observed() !== 25'd0) begin
                bad++;
                $display("FAIL reset cyc%0d: got %h want 0", i, observed());
            end
        end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, code_tab[i]);
            total++;
            if (observed() !== expected() || bin_out !== 3'(i) || locked !== (i == 4)) begin
                bad++;
                $display("FAIL lock step%0d: got %h want %h (bin=%0d locked=%b)",
                         i, observed(), expected(), bin_out, locked);
            end
        end
    endtask

    task automatic test_wrap();
        int seq [4] = '{5, 6, 7, 0};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, code_tab[seq[i]]);
            total++;
            if (observed() !== expected() || bin_out !== 3'(seq[i]) || locked !== 1'b1
                || seq_err !== 1'b0 || err_count !== 8'd0) begin
                bad++;
                $display("FAIL wrap step%0d: got %h want %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_seq_err();
        cycle(0, 1, code_tab[1]);
        cycle(0, 1, code_tab[2]);
        total++;
        if (locked !== 1'b1 || bin_out !== 3'd2) begin
            bad++;
            $display("FAIL seqerr_pre: got locked=%b bin=%0d want locked=1 bin=2", locked, bin_out);
        end
        cycle(0, 1, 4'b1110);
        total++;
        if (observed() !== expected() || seq_err !== 1'b1 || bin_out !== 3'd5
            || locked !== 1'b0 || err_count !== 8'd1) begin
            bad++;
            $display("FAIL seqerr: got %h want %h", observed(), expected());
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 4'b0101);
            total++;
            if (observed() !== expected() || illegal !== 1'b1 || onehot_out !== 8'd0
                || seq_err !== 1'b0 || err_count !== 8'(2 + i)) begin
                bad++;
                $display("FAIL illegal%0d: got %h want %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_random();
        int cur = 0;
        int r;
        logic [3:0] c;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      begin cur = (cur + 1) % NS; c = code_tab[cur]; end
            else if (r < 70) c = code_tab[cur];
            else if (r < 78) begin cur = (cur + NS - 1) % NS; c = code_tab[cur]; end
            else if (r < 88) begin cur = int'($urandom_range(0, NS - 1)); c = code_tab[cur]; end
            else             c = 4'($urandom_range(0, 15));
            cycle(0, ($urandom_range(0, 4) != 0), c);
            total++;
            if (observed() !== expected()) begin
                bad++;
                $display("FAIL random step%0d code=%b: got %h want %h", i, c, observed(), expected());
            end
        end
    endtask

    task automatic test_saturate_and_reset();
        logic [3:0] bad_codes [5] = '{4'b0101, 4'b1010, 4'b0010, 4'b1011, 4'b0100};
        cycle(1, 0, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, bad_codes[i]);
            total++;
            if (observed() !== expected() || err2 !== 2'((i + 1 > 3) ? 3 : i + 1)
                || err_count !== 8'(i + 1)) begin
                bad++;
                $display("FAIL saturate%0d: got %h want %h", i, observed(), expected());
            end
        end
        for (int i = 0; i < 3; i++) cycle(0, 1, code_tab[i]);
        cycle(1, 1, code_tab[3]);
        total++;
        if (observed() !== 25'd0 || observed() !== expected()) begin
            bad++;
            $display("FAIL midreset: got %h want 0", observed());
        end
        cycle(0, 1, code_tab[4]);
        total++;
        if (observed() !== expected() || locked !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: got %h want %h", observed(), expected());
        end
    endtask

    initial begin
        logic [3:0] c;
        c = 4'b0000;
        for (int i = 0; i < NS; i++) begin
            code_tab[i] = c;
            c = {c[2:0], ~c[3]};
        end
        model_reset();
        test_reset();
        test_lock();
        test_wrap();
        test_seq_err();
        test_illegal();
        test_random();
        test_saturate_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
